// File: rtl/axil_pkg.sv
// Shared types and default widths for the AXI4-Lite initiator.
//
// Contents:
//   resp_t   - AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   state_t  - transaction FSM states of axil_master
//   AXIL_*   - default parameter values used by axil_master
package axil_pkg;

  localparam int unsigned AXIL_ADDR_WIDTH     = 8;
  localparam int unsigned AXIL_DATA_WIDTH     = 32;
  localparam int unsigned AXIL_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns a command/response stream into single AXI-Lite
// read or write transactions on the cbus_ interface, one at a time. Every
// bus response (including SLVERR/DECERR) is handed back unchanged.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cmd_ready=1, waiting for a command
// WRITE  | AW and W offered; each valid drops after its own handshake
// WRESP  | bready=1, waiting for the B beat
// READ   | arvalid=1, waiting for the AR handshake
// RDATA  | rready=1, waiting for the R beat
// RESP   | rsp_valid=1, held until rsp_ready
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command stream in
//   rsp_valid/ready/write/rdata/resp          response stream out
//   cbus_aw*, cbus_w*, cbus_b*, cbus_ar*, cbus_r*   AXI4-Lite master
//   timeout                        sticky watchdog flag (only when the
//                                  AXIL_MASTER_TIMEOUT_EN macro is defined)
//
// DATA_WIDTH must be 32 or 64.
module axil_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AXIL_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = AXIL_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = AXIL_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rstn,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,

  output logic [ADDR_WIDTH-1:0]     cbus_awaddr,
  output logic                      cbus_awvalid,
  input  logic                      cbus_awready,
  output logic [DATA_WIDTH-1:0]     cbus_wdata,
  output logic [DATA_WIDTH/8-1:0]   cbus_wstrb,
  output logic                      cbus_wvalid,
  input  logic                      cbus_wready,
  input  logic [1:0]                cbus_bresp,
  input  logic                      cbus_bvalid,
  output logic                      cbus_bready,
  output logic [ADDR_WIDTH-1:0]     cbus_araddr,
  output logic                      cbus_arvalid,
  input  logic                      cbus_arready,
  input  logic [DATA_WIDTH-1:0]     cbus_rdata,
  input  logic [1:0]                cbus_rresp,
  input  logic                      cbus_rvalid,
  output logic                      cbus_rready
`ifdef AXIL_MASTER_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  state_t state_q;
  state_t state_d;
  logic   aw_done;
  logic   w_done;

  assign cmd_ready = (state_q == IDLE);

  // A channel is finished once its valid is gone or is being accepted now.
  assign aw_done = !cbus_awvalid || cbus_awready;
  assign w_done  = !cbus_wvalid  || cbus_wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid)                   state_d = cmd_write ? WRITE : READ;
      WRITE:   if (aw_done && w_done)           state_d = WRESP;
      WRESP:   if (cbus_bvalid && cbus_bready)  state_d = RESP;
      READ:    if (cbus_arvalid && cbus_arready) state_d = RDATA;
      RDATA:   if (cbus_rvalid && cbus_rready)  state_d = RESP;
      RESP:    if (rsp_ready)                   state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cbus_awaddr  <= '0;
      cbus_awvalid <= 1'b0;
      cbus_wdata   <= '0;
      cbus_wstrb   <= '0;
      cbus_wvalid  <= 1'b0;
      cbus_bready  <= 1'b0;
      cbus_araddr  <= '0;
      cbus_arvalid <= 1'b0;
      cbus_rready  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= 2'b00;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Address/data registers only load here, so they stay stable
          // for as long as the matching valid is high.
          if (cmd_valid) begin
            if (cmd_write) begin
              cbus_awaddr  <= cmd_addr;
              cbus_wdata   <= cmd_wdata;
              cbus_wstrb   <= cmd_wstrb;
              cbus_awvalid <= 1'b1;
              cbus_wvalid  <= 1'b1;
            end else begin
              cbus_araddr  <= cmd_addr;
              cbus_arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (cbus_awvalid && cbus_awready) cbus_awvalid <= 1'b0;
          if (cbus_wvalid && cbus_wready)   cbus_wvalid  <= 1'b0;
          if (aw_done && w_done)            cbus_bready  <= 1'b1;
        end
        WRESP: begin
          if (cbus_bvalid && cbus_bready) begin
            rsp_resp    <= cbus_bresp;
            rsp_rdata   <= '0;
            rsp_write   <= 1'b1;
            rsp_valid   <= 1'b1;
            cbus_bready <= 1'b0;
          end
        end
        READ: begin
          if (cbus_arvalid && cbus_arready) begin
            cbus_arvalid <= 1'b0;
            cbus_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (cbus_rvalid && cbus_rready) begin
            rsp_rdata   <= cbus_rdata;
            rsp_resp    <= cbus_rresp;
            rsp_write   <= 1'b0;
            rsp_valid   <= 1'b1;
            cbus_rready <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int unsigned           TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            bus_busy;

  assign bus_busy = (state_q == WRITE) || (state_q == WRESP) ||
                    (state_q == READ)  || (state_q == RDATA);

  // Watchdog only flags; the transaction keeps running so the bus stays
  // protocol-legal. The count saturates at its limit instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        to_cnt_q <= '0;
      end else if (bus_busy && (to_cnt_q != TO_LAST)) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (bus_busy && (to_cnt_q == TO_LAST)) timeout <= 1'b1;
    end
  end
`else
  // Keeps the watchdog parameter referenced in builds without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_axil_master.sv
`timescale 1ns/1ps
module tb_axil_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TC = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  logic [AW-1:0] cbus_awaddr;
  logic          cbus_awvalid;
  logic          cbus_awready = 1'b0;
  logic [DW-1:0] cbus_wdata;
  logic [SW-1:0] cbus_wstrb;
  logic          cbus_wvalid;
  logic          cbus_wready = 1'b0;
  logic [1:0]    cbus_bresp = 2'b00;
  logic          cbus_bvalid = 1'b0;
  logic          cbus_bready;
  logic [AW-1:0] cbus_araddr;
  logic          cbus_arvalid;
  logic          cbus_arready = 1'b0;
  logic [DW-1:0] cbus_rdata = '0;
  logic [1:0]    cbus_rresp = 2'b00;
  logic          cbus_rvalid = 1'b0;
  logic          cbus_rready;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic          timeout;
`endif

  axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .cbus_awaddr  (cbus_awaddr),
    .cbus_awvalid (cbus_awvalid),
    .cbus_awready (cbus_awready),
    .cbus_wdata   (cbus_wdata),
    .cbus_wstrb   (cbus_wstrb),
    .cbus_wvalid  (cbus_wvalid),
    .cbus_wready  (cbus_wready),
    .cbus_bresp   (cbus_bresp),
    .cbus_bvalid  (cbus_bvalid),
    .cbus_bready  (cbus_bready),
    .cbus_araddr  (cbus_araddr),
    .cbus_arvalid (cbus_arvalid),
    .cbus_arready (cbus_arready),
    .cbus_rdata   (cbus_rdata),
    .cbus_rresp   (cbus_rresp),
    .cbus_rvalid  (cbus_rvalid),
    .cbus_rready  (cbus_rready)
`ifdef AXIL_MASTER_TIMEOUT_EN
   ,.timeout      (timeout)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // ---------------- responder configuration (written by stimulus only)
  int         cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_b_wait = 0, cfg_r_wait = 0;
  bit         cfg_ar_hold = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  bit         cfg_rforce = 0;
  logic [DW-1:0] cfg_rdata = '0;

  // ---------------- behavioural AXI-Lite responder, acts on negedges
  logic [DW-1:0] slv_mem [256];
  int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, proto_err = 0;
  int  aw_dn, w_dn, ar_dn, b_dn, r_dn;
  bit  got_aw, got_w, got_ar, b_armed;
  logic [AW-1:0] s_awaddr, s_araddr, p_awaddr, p_araddr;
  logic [DW-1:0] s_wdata, p_wdata;
  logic [SW-1:0] s_wstrb, p_wstrb;
  bit  p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;

  always @(negedge clk) begin
    if (!rstn) begin
      cbus_awready = 0; cbus_wready = 0; cbus_arready = 0;
      cbus_bvalid = 0; cbus_rvalid = 0; cbus_bresp = 0; cbus_rresp = 0; cbus_rdata = 0;
      got_aw = 0; got_w = 0; got_ar = 0; b_armed = 0;
      aw_dn = 0; w_dn = 0; ar_dn = 0; b_dn = 0; r_dn = 0;
      for (int i = 0; i < 256; i++) slv_mem[i] = init_word(i);
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      p_bv = 0; p_br = 0; p_rv = 0; p_rr = 0;
    end else begin
      // Handshakes at the rising edge just passed (values seen last negedge).
      if (p_awv && p_awr) begin
        aw_cnt++; got_aw = 1; s_awaddr = p_awaddr; cbus_awready = 0;
        if (cbus_awvalid) proto_err++;
      end else if (p_awv && (!cbus_awvalid || cbus_awaddr !== p_awaddr)) proto_err++;
      if (p_wv && p_wr) begin
        w_cnt++; got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; cbus_wready = 0;
        if (cbus_wvalid) proto_err++;
      end else if (p_wv && (!cbus_wvalid || cbus_wdata !== p_wdata || cbus_wstrb !== p_wstrb)) proto_err++;
      if (p_arv && p_arr) begin
        ar_cnt++; got_ar = 1; s_araddr = p_araddr; cbus_arready = 0; r_dn = cfg_r_wait;
        if (cbus_arvalid) proto_err++;
      end else if (p_arv && (!cbus_arvalid || cbus_araddr !== p_araddr)) proto_err++;
      if (p_bv && p_br) begin
        b_cnt++; cbus_bvalid = 0; got_aw = 0; got_w = 0; b_armed = 0;
      end
      if (p_rv && p_rr) begin
        r_cnt++; cbus_rvalid = 0; got_ar = 0;
      end

      if (!p_awv && cbus_awvalid) aw_dn = cfg_aw_wait;
      if (!p_wv  && cbus_wvalid)  w_dn  = cfg_w_wait;
      if (!p_arv && cbus_arvalid) ar_dn = cfg_ar_wait;
      if (cbus_awvalid && !cbus_awready) begin
        if (aw_dn == 0) cbus_awready = 1; else aw_dn--;
      end
      if (cbus_wvalid && !cbus_wready) begin
        if (w_dn == 0) cbus_wready = 1; else w_dn--;
      end
      if (cbus_arvalid && !cbus_arready && !cfg_ar_hold) begin
        if (ar_dn == 0) cbus_arready = 1; else ar_dn--;
      end
      if (got_aw && got_w && !b_armed) begin
        b_armed = 1; b_dn = cfg_b_wait;
      end
      if (b_armed && !cbus_bvalid) begin
        if (b_dn == 0) begin
          cbus_bvalid = 1; cbus_bresp = cfg_bresp;
          if (cfg_bresp < 2)
            for (int b = 0; b < SW; b++)
              if (s_wstrb[b]) slv_mem[s_awaddr][8*b +: 8] = s_wdata[8*b +: 8];
        end else b_dn--;
      end
      if (got_ar && !cbus_rvalid) begin
        if (r_dn == 0) begin
          cbus_rvalid = 1; cbus_rresp = cfg_rresp;
          cbus_rdata = cfg_rforce ? cfg_rdata : slv_mem[s_araddr];
        end else r_dn--;
      end

      p_awv = cbus_awvalid; p_awr = cbus_awready; p_awaddr = cbus_awaddr;
      p_wv  = cbus_wvalid;  p_wr  = cbus_wready;  p_wdata = cbus_wdata; p_wstrb = cbus_wstrb;
      p_arv = cbus_arvalid; p_arr = cbus_arready; p_araddr = cbus_araddr;
      p_bv  = cbus_bvalid;  p_br  = cbus_bready;
      p_rv  = cbus_rvalid;  p_rr  = cbus_rready;
    end
  end

  // ---------------- reference model: memory contents as the requester sees them
  logic [DW-1:0] ref_mem [256];

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // One command end to end: expectation from the model, issue, collect the
  // response (optionally holding rsp_ready low), then check bus beat counts.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input int hold, input bit chk_lat);
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
    int n, aw0, w0, b0, ar0, r0;
    bit hold_ok;
    if (wr) begin
      exp_resp = cfg_bresp;
      exp_data = '0;
      if (cfg_bresp < 2)
        for (int b = 0; b < SW; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_resp = cfg_rresp;
      exp_data = cfg_rforce ? cfg_rdata : ref_mem[a];
    end
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;

    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    n = 1;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    check("rsp_valid", rsp_valid, 1);
    if (chk_lat) check("latency", n, 3);
    check("rsp_write", rsp_write, wr);
    check("rsp_resp", rsp_resp, exp_resp);
    check("rsp_rdata", rsp_rdata, exp_data);
    check("cmd_ready_busy", cmd_ready, 0);

    hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data || rsp_resp !== exp_resp || cmd_ready !== 1'b0)
        hold_ok = 0;
    end
    if (hold > 0) check("rsp_hold_stable", hold_ok, 1);

    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_drop", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("aw_beats", aw_cnt - aw0, wr ? 1 : 0);
    check("w_beats",  w_cnt - w0,   wr ? 1 : 0);
    check("b_beats",  b_cnt - b0,   wr ? 1 : 0);
    check("ar_beats", ar_cnt - ar0, wr ? 0 : 1);
    check("r_beats",  r_cnt - r0,   wr ? 0 : 1);
    check("protocol", proto_err, 0);
  endtask

  task automatic cfg_zero();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_b_wait = 0; cfg_r_wait = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rforce = 0; cfg_ar_hold = 0;
  endtask

  initial begin
    int n;
    ref_init();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {rsp_valid, rsp_write, rsp_rdata, rsp_resp, cbus_awvalid, cbus_wvalid,
           cbus_bready, cbus_arvalid, cbus_rready, cbus_awaddr, cbus_araddr}, 0);
    check("reset_cmd_ready", cmd_ready, 1);
`ifdef AXIL_MASTER_TIMEOUT_EN
    check("reset_timeout", timeout, 0);
`endif
    rstn = 1;
    @(negedge clk);

    // Zero-wait latency, write then read.
    cfg_zero();
    run_cmd(1, 8'h20, 32'h1234_5678, 4'hF, 0, 1);
    run_cmd(0, 8'h20, '0, '0, 0, 1);

    // Readies delayed by one cycle; write 0xA5 then read it back.
    cfg_aw_wait = 1; cfg_w_wait = 1;
    run_cmd(1, 8'h01, 32'h0000_00A5, 4'hF, 0, 0);
    run_cmd(0, 8'h01, '0, '0, 0, 0);

    // W accepted three cycles before AW.
    cfg_zero(); cfg_aw_wait = 3;
    run_cmd(1, 8'h02, 32'hCAFE_F00D, 4'h5, 0, 0);

    // Error read passes through with injected data.
    cfg_zero(); cfg_rresp = 2'd2; cfg_rforce = 1; cfg_rdata = 32'hDEAD_BEEF;
    run_cmd(0, 8'h07, '0, '0, 0, 0);

    // Response held off for five cycles.
    cfg_zero();
    run_cmd(0, 8'h02, '0, '0, 5, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      cfg_aw_wait = $urandom_range(0, 3); cfg_w_wait = $urandom_range(0, 3);
      cfg_ar_wait = $urandom_range(0, 3); cfg_b_wait = $urandom_range(0, 3);
      cfg_r_wait  = $urandom_range(0, 3);
      cfg_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cfg_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cfg_rforce = 0;
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
              SW'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
    end

    // Reset while a write is stalled in WRITE.
    cfg_zero(); cfg_aw_wait = 20; cfg_w_wait = 20;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h03; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    check("pre_reset_awvalid", cbus_awvalid, 1);
    #1 rstn = 0;
    #1;
    check("async_reset_handshake",
          {cbus_awvalid, cbus_wvalid, cbus_bready, cbus_arvalid, cbus_rready, rsp_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    cfg_zero();
    ref_init();
    check("post_reset_cmd_ready", cmd_ready, 1);
    run_cmd(0, 8'h03, '0, '0, 0, 1);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Responder withholds arready; watchdog flags but the read still completes.
    cfg_zero(); cfg_ar_hold = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h05;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 16) check("timeout_early", timeout, 0);
      if (k == 17) begin
        check("timeout_set", timeout, 1);
        check("timeout_arvalid", cbus_arvalid, 1);
      end
      if (k < 17) @(negedge clk);
    end
    cfg_ar_hold = 0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("timeout_rsp_valid", rsp_valid, 1);
    check("timeout_rsp_rdata", rsp_rdata, ref_mem[5]);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("timeout_sticky", timeout, 1);
`endif

    n = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- AXI4-Lite initiator that turns a simple command/response stream into AXI-Lite read and write transactions on the `cbus_` interface.
- Drives CSR responder blocks from a sequencer or debug bridge.
- One transaction in flight at a time.
- Every response, including SLVERR/DECERR, is returned to the requester unchanged.

Parameters:
- ADDR_WIDTH, 8, width of `cmd_addr`, `cbus_awaddr` and `cbus_araddr`.
- DATA_WIDTH, 32, width of data buses; must be 32 or 64.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when AXIL_MASTER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with `cmd_valid`.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of `cmd_write`.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- cbus_awaddr  out  ADDR_WIDTH
- cbus_awvalid  out  1
- cbus_awready  in  1
- cbus_wdata  out  DATA_WIDTH
- cbus_wstrb  out  DATA_WIDTH/8
- cbus_wvalid  out  1
- cbus_wready  in  1
- cbus_bresp  in  2
- cbus_bvalid  in  1
- cbus_bready  out  1
- cbus_araddr  out  ADDR_WIDTH
- cbus_arvalid  out  1
- cbus_arready  in  1
- cbus_rdata  in  DATA_WIDTH
- cbus_rresp  in  2
- cbus_rvalid  in  1
- cbus_rready  out  1
- timeout  out  1  exists only with AXIL_MASTER_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rstn` is asynchronous, active-low.
- Reset values: all outputs registered and 0 in reset, except `cmd_ready`, which is combinational (`state==IDLE`).
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`: capture addr/wdata/wstrb/write.
  - Write → WRITE, with `cbus_awvalid` and `cbus_wvalid` both 1 from the next cycle.
  - Read → READ, with `cbus_arvalid`=1 from the next cycle.
- WRITE:
  - AW and W complete independently; each valid drops the cycle after its own handshake.
  - Either order, or both in the same cycle, is legal.
  - When both are done → WRESP, with `cbus_bready`=1.
  - Valids never drop before their handshake; addr/data/strb stay stable while valid.
- WRESP: on `cbus_bvalid&&cbus_bready`, latch `bresp`, set `rsp_rdata`=0, `rsp_write`=1, `bready`←0 → RESP.
- READ: on `cbus_arvalid&&cbus_arready`, `arvalid`←0, `rready`←1 → RDATA.
- RDATA: on `rvalid&&rready`, latch `rdata`/`rresp`, `rready`←0 → RESP.
- RESP: `rsp_valid`=1; outputs stay stable until `rsp_ready` is seen, then `rsp_valid`←0 → IDLE.
- Next command is accepted no earlier than the cycle after the response is consumed.
- Latency with zero-wait responder: write = 3 cycles from command accept to `rsp_valid`; read = 3 cycles.
- Responses other than OKAY are not retried; they are passed through.
- Spurious `cbus_bvalid`/`cbus_rvalid` in other states are ignored, since the corresponding ready is 0.
- Reset mid-transaction: all valids and readies drop immediately (asynchronous); state → IDLE; the pending transaction is lost.

Optional Feature:
- Macro AXIL_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on every state change and increments in each cycle spent in WRITE/WRESP/READ/RDATA.
  - On reaching TIMEOUT_CYCLES-1, `timeout` becomes sticky 1 until reset.
  - The transaction is not aborted, so the AXI protocol stays legal.
- Undefined: no counter and no `timeout` port.

Decomposition:
- Package `axil_pkg`:
  - `resp_t` enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - `state_t` enum.
  - Default width localparams.
- No sub-module is required; the AXI responder is behavioural, in the bench.

Test Plan:
1. Write 0xA5 to addr 1, wstrb 0xF; responder readies delayed by 1 cycle → one AW handshake and one W handshake, `rsp_valid` with `rsp_resp`=0 and `rsp_write`=1; a following read of addr 1 returns 0xA5.
2. Responder accepts W 3 cycles before AW → `wvalid` drops after its handshake; `awvalid` stays high with stable addr until accepted; exactly one B consumed.
3. Read with responder returning RRESP=2 and rdata 0xDEADBEEF → `rsp_resp`=2, `rsp_rdata`=0xDEADBEEF.
4. `rsp_ready` held 0 for 5 cycles → `rsp_valid` and `rsp_rdata` stable, `cmd_ready`=0 throughout; the next command is accepted only after the response handshake.
5. `rstn` asserted while in WRITE with `awvalid`=1 → all cbus valids/readies 0 in the same cycle; after release, `cmd_ready`=1 and a fresh read completes normally.
6. With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16: responder never asserts `arready` → `timeout`=1 after 16 cycles in READ, `arvalid` still 1; on a later `arready` the read completes and `timeout` stays 1.
